// File: rtl/pcpi_matrix_initiator.sv
// Host-to-PCPI command initiator for the fused matrix-multiply coprocessor.
// Encodes one host command at a time, runs the PCPI handshake with a timeout and returns one response.
module pcpi_matrix_initiator #(
  parameter logic [6:0] OPCODE   = 7'b0001011,
  parameter int         TIMEOUT  = 64,
  parameter int         MAX_ADDR = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [1:0]  host_op,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  localparam int               CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [4:0]       ADDR_LIMIT = 5'(MAX_ADDR);

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_CLEAR   = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;

  localparam logic [2:0] F3_LOAD    = 3'b000;
  localparam logic [2:0] F3_CLEAR   = 3'b101;
  localparam logic [2:0] F3_COMPUTE = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_pcpi_valid;
  logic [31:0]      r_pcpi_insn;
  logic             r_resp_valid;
  logic [31:0]      r_resp_data;
  logic             r_resp_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_legal;
  logic [2:0]       w_funct3;
  logic [4:0]       w_addr;
  logic [15:0]      w_value;
  logic [31:0]      w_insn;

  assign host_ready = (r_state == S_IDLE) && !rst;
  assign busy       = (r_state != S_IDLE);
  assign pcpi_valid = r_pcpi_valid;
  assign pcpi_insn  = r_pcpi_insn;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

  assign w_accept = host_valid && host_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_legal  = 1'b0;
    w_funct3 = 3'b000;
    w_addr   = 5'd0;
    w_value  = 16'd0;
    case (host_op)
      OP_LOAD: begin
        if (host_addr <= ADDR_LIMIT) begin
          w_legal  = 1'b1;
          w_funct3 = F3_LOAD;
          w_addr   = host_addr;
          w_value  = host_data;
        end
      end
      OP_CLEAR: begin
        w_legal  = 1'b1;
        w_funct3 = F3_CLEAR;
      end
      OP_COMPUTE: begin
        w_legal  = 1'b1;
        w_funct3 = F3_COMPUTE;
      end
      default: ;
    endcase
  end

  assign w_insn = {1'b0, w_value, w_funct3, w_addr, OPCODE};

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pcpi_valid <= 1'b0;
      r_pcpi_insn  <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_state      <= S_ISSUE;
              r_pcpi_valid <= 1'b1;
              r_pcpi_insn  <= w_insn;
              r_cnt        <= '0;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= 32'd0;
              r_resp_err   <= 1'b1;
            end
          end
        end
        // A ready still held from the previous command is stale, so it is not looked at here.
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          if (pcpi_ready) begin
            r_state      <= S_RESP;
            r_pcpi_valid <= 1'b0;
            r_pcpi_insn  <= 32'd0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= pcpi_wr ? pcpi_rd : 32'd0;
            r_resp_err   <= 1'b0;
          end else if (r_cnt == CNT_LIMIT) begin
            r_state      <= S_RESP;
            r_pcpi_valid <= 1'b0;
            r_pcpi_insn  <= 32'd0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= 32'd0;
            r_resp_err   <= 1'b1;
          end else if (!pcpi_wait) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
